// File: rtl/seu_ff_scrubber_pkg.sv
// Shared types for the triplicated-file scrubber: FSM encoding and replica count.
package p_hardisc;

    localparam int REPLICAS = 3;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        FIX  = 2'd3
    } scrub_state_t;

endpackage

// File: rtl/seu_ff_rst.sv
// Resettable flip-flop bank; scrubber state lives here so fault injection can reach it.
module seu_ff_rst #(
    parameter int            W       = 1,
    parameter int            N       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic                s_c_i,
    input  logic                s_r_i,
    input  logic [N-1:0][W-1:0] s_d_i,
    output logic [N-1:0][W-1:0] s_q_o
);

    always_ff @(posedge s_c_i or negedge s_r_i) begin
        if (!s_r_i) begin
            s_q_o <= {N{RST_VAL}};
        end else begin
            s_q_o <= s_d_i;
        end
    end

endmodule

// File: rtl/seu_word_voter.sv
// Bitwise 2-of-3 majority over one word, plus any-mismatch and no-pair-agrees flags.
module seu_word_voter
    import p_hardisc::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] s_rd_i [REPLICAS],
    output logic [W-1:0] s_v_o,
    output logic         s_mis_o,
    output logic         s_unc_o
);

    logic eq_ab;
    logic eq_ac;
    logic eq_bc;

    assign eq_ab = (s_rd_i[0] == s_rd_i[1]);
    assign eq_ac = (s_rd_i[0] == s_rd_i[2]);
    assign eq_bc = (s_rd_i[1] == s_rd_i[2]);

    assign s_v_o   = (s_rd_i[0] & s_rd_i[1]) | (s_rd_i[0] & s_rd_i[2]) | (s_rd_i[1] & s_rd_i[2]);
    assign s_mis_o = !(eq_ab && eq_bc);
    assign s_unc_o = !(eq_ab || eq_ac || eq_bc);

endmodule

// File: rtl/seu_ff_scrubber.sv
// Background scrubber for a triplicated register file: periodically votes one entry
// and rewrites it when replicas disagree, yielding to core writes on the shared port.
//
// state | meaning
// IDLE  | scrubbing disabled, pointer retained
// WAIT  | counting idle cycles before the next step
// READ  | voting entry at ptr
// FIX   | writing voted word back to all replicas
module seu_ff_scrubber
    import p_hardisc::*;
#(
    parameter int W      = 32,
    parameter int N      = 32,
    parameter int ADDW   = $clog2(N),
    parameter int PERIOD = 64
) (
    input  logic             s_c_i,
    input  logic             s_r_i,
    input  logic             s_en_i,
    input  logic             s_we_i,
    input  logic [ADDW-1:0]  s_wa_i,
    input  logic [W-1:0]     s_d_i,
    input  logic [W-1:0]     s_rd_i [REPLICAS],
    output logic [ADDW-1:0]  s_ra_o,
    output logic             s_we_o,
    output logic [ADDW-1:0]  s_wa_o,
    output logic [W-1:0]     s_wd_o,
    output logic             s_fix_o,
    output logic             s_unc_o,
    output logic             s_pass_o,
    output logic [CNT_W-1:0] s_fix_cnt_o,
    output logic             s_busy_o
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [ADDW-1:0]  LAST      = ADDW'(N - 1);

    scrub_state_t     state_q;
    scrub_state_t     state_d;
    logic [1:0]       state_bits_q;
    logic [1:0]       state_bits_d;
    logic [ADDW-1:0]  ptr_q;
    logic [ADDW-1:0]  ptr_d;
    logic [W-1:0]     v_q;
    logic [W-1:0]     v_d;
    logic [CNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0] wcnt_d;
    logic [CNT_W-1:0] fix_cnt_q;
    logic [CNT_W-1:0] fix_cnt_d;

    logic [W-1:0]     maj;
    logic             mis;
    logic             unc;
    logic             fix_wr;
    logic             advance;

    seu_word_voter #(.W(W)) u_voter (
        .s_rd_i  (s_rd_i),
        .s_v_o   (maj),
        .s_mis_o (mis),
        .s_unc_o (unc)
    );

    assign state_bits_d = state_d;
    assign state_q      = scrub_state_t'(state_bits_q);

    seu_ff_rst #(.W(2), .N(1)) u_state_ff (
        .s_c_i (s_c_i),
        .s_r_i (s_r_i),
        .s_d_i (state_bits_d),
        .s_q_o (state_bits_q)
    );

    seu_ff_rst #(.W(ADDW), .N(1)) u_ptr_ff (
        .s_c_i (s_c_i),
        .s_r_i (s_r_i),
        .s_d_i (ptr_d),
        .s_q_o (ptr_q)
    );

    seu_ff_rst #(.W(W), .N(1)) u_v_ff (
        .s_c_i (s_c_i),
        .s_r_i (s_r_i),
        .s_d_i (v_d),
        .s_q_o (v_q)
    );

    always_ff @(posedge s_c_i or negedge s_r_i) begin
        if (!s_r_i) begin
            wcnt_q    <= '0;
            fix_cnt_q <= '0;
        end else begin
            wcnt_q    <= wcnt_d;
            fix_cnt_q <= fix_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        v_d       = v_q;
        wcnt_d    = wcnt_q;
        fix_cnt_d = fix_cnt_q;
        fix_wr    = 1'b0;
        advance   = 1'b0;
        s_fix_o   = 1'b0;
        s_unc_o   = 1'b0;
        s_pass_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_en_i) begin
                    state_d = WAIT;
                    wcnt_d  = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (!s_en_i) begin
                    state_d = IDLE;
                end else if (wcnt_q == '0) begin
                    state_d = READ;
                end else begin
                    wcnt_d = wcnt_q - CNT_W'(1);
                end
            end
            READ: begin
                // A core write in flight may be changing the entry; retry next cycle.
                if (!s_en_i) begin
                    state_d = IDLE;
                end else if (!s_we_i) begin
                    v_d = maj;
                    if (!mis) begin
                        advance = 1'b1;
                        state_d = WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d = FIX;
                        s_unc_o = unc;
                    end
                end
            end
            FIX: begin
                if (!s_we_i) begin
                    fix_wr  = 1'b1;
                    s_fix_o = 1'b1;
                    if (fix_cnt_q != CNT_MAX) begin
                        fix_cnt_d = fix_cnt_q + CNT_W'(1);
                    end
                    advance = 1'b1;
                    state_d = WAIT;
                    wcnt_d  = WAIT_LOAD;
                end else if (s_wa_i == ptr_q) begin
                    // Core overwrote the faulty entry, so the repair is moot.
                    advance = 1'b1;
                    state_d = WAIT;
                    wcnt_d  = WAIT_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (ptr_q == LAST) begin
                ptr_d    = '0;
                s_pass_o = 1'b1;
            end else begin
                ptr_d = ptr_q + ADDW'(1);
            end
        end
    end

    always_comb begin
        s_we_o = 1'b0;
        s_wa_o = '0;
        s_wd_o = '0;
        if (s_we_i) begin
            s_we_o = 1'b1;
            s_wa_o = s_wa_i;
            s_wd_o = s_d_i;
        end else if (fix_wr) begin
            s_we_o = 1'b1;
            s_wa_o = ptr_q;
            s_wd_o = v_q;
        end
    end

    assign s_ra_o      = ptr_q;
    assign s_busy_o    = (state_q == READ) || (state_q == FIX);
    assign s_fix_cnt_o = fix_cnt_q;

endmodule

// File: tb/tb_seu_ff_scrubber.sv
// Directed bench for seu_ff_scrubber with a three-replica memory model behind the ports.
module tb_seu_ff_scrubber;

    localparam int W      = 32;
    localparam int N      = 8;
    localparam int ADDW   = 3;
    localparam int PERIOD = 4;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            we_i;
    logic [ADDW-1:0] wa_i;
    logic [W-1:0]    d_i;
    logic [W-1:0]    rd [3];
    logic [ADDW-1:0] ra;
    logic            we_o;
    logic [ADDW-1:0] wa_o;
    logic [W-1:0]    wd_o;
    logic            fix;
    logic            unc;
    logic            pass;
    logic [15:0]     fix_cnt;
    logic            busy;

    logic [W-1:0]    mem [3][N];
    logic            mem_clr;
    logic            inj_valid;
    logic [ADDW-1:0] inj_addr;
    logic [W-1:0]    inj_v [3];

    int n_assert = 0;
    int n_fail   = 0;

    seu_ff_scrubber #(.W(W), .N(N), .ADDW(ADDW), .PERIOD(PERIOD)) dut (
        .s_c_i       (clk),
        .s_r_i       (rst_n),
        .s_en_i      (en),
        .s_we_i      (we_i),
        .s_wa_i      (wa_i),
        .s_d_i       (d_i),
        .s_rd_i      (rd),
        .s_ra_o      (ra),
        .s_we_o      (we_o),
        .s_wa_o      (wa_o),
        .s_wd_o      (wd_o),
        .s_fix_o     (fix),
        .s_unc_o     (unc),
        .s_pass_o    (pass),
        .s_fix_cnt_o (fix_cnt),
        .s_busy_o    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int r = 0; r < 3; r++) rd[r] = mem[r][ra];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int r = 0; r < 3; r++)
                for (int a = 0; a < N; a++) mem[r][a] <= '0;
        end else begin
            if (we_o)
                for (int r = 0; r < 3; r++) mem[r][wa_o] <= wd_o;
            if (inj_valid)
                for (int r = 0; r < 3; r++) mem[r][inj_addr] <= inj_v[r];
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reach"}, 32'(busy), 32'd1);
    endtask

    task automatic inject(int addr, logic [31:0] v0, logic [31:0] v1, logic [31:0] v2);
        inj_addr  = ADDW'(addr);
        inj_v[0]  = v0;
        inj_v[1]  = v1;
        inj_v[2]  = v2;
        inj_valid = 1'b1;
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
    endtask

    initial begin
        int busy_seen;
        rst_n     = 1'b0;
        en        = 1'b0;
        we_i      = 1'b0;
        wa_i      = '0;
        d_i       = '0;
        mem_clr   = 1'b1;
        inj_valid = 1'b0;
        inj_addr  = '0;
        for (int r = 0; r < 3; r++) inj_v[r] = '0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;

        // reset state and pass-through during reset
        chk("rst_ra",    32'(ra),      32'd0);
        chk("rst_we",    32'(we_o),    32'd0);
        chk("rst_fix",   32'(fix),     32'd0);
        chk("rst_unc",   32'(unc),     32'd0);
        chk("rst_pass",  32'(pass),    32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_cnt",   32'(fix_cnt), 32'd0);
        we_i = 1'b1; wa_i = 3'd3; d_i = 32'h77;
        #1;
        chk("rst_pt_we", 32'(we_o), 32'd1);
        chk("rst_pt_wa", 32'(wa_o), 32'd3);
        chk("rst_pt_wd", 32'(wd_o), 32'h77);
        we_i = 1'b0;
        #1;
        chk("rst_pt_off", 32'(we_o), 32'd0);

        // clean pass over all entries
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < N; k++) begin
            wait_busy("clean");
            chk("clean_ra",   32'(ra),   32'(k));
            chk("clean_pass", 32'(pass), 32'(k == N - 1));
            chk("clean_fix",  32'(fix),  32'd0);
        end
        inject(2, 32'h0, 32'h1, 32'h0);
        inject(3, 32'h1, 32'h2, 32'h4);
        chk("clean_cnt", 32'(fix_cnt), 32'd0);

        // single-bit error in replica 1 of entry 2
        wait_busy("e0");
        chk("e0_ra", 32'(ra), 32'd0);
        wait_busy("e1");
        chk("e1_ra", 32'(ra), 32'd1);
        wait_busy("e2");
        chk("e2_ra",  32'(ra),  32'd2);
        chk("e2_unc", 32'(unc), 32'd0);
        @(negedge clk);
        chk("e2_fix_we",  32'(we_o), 32'd1);
        chk("e2_fix_wa",  32'(wa_o), 32'd2);
        chk("e2_fix_wd",  32'(wd_o), 32'd0);
        chk("e2_fix_pls", 32'(fix),  32'd1);
        @(negedge clk);
        chk("e2_cnt", 32'(fix_cnt), 32'd1);
        chk("e2_mem", mem[1][2],    32'd0);

        // no two replicas agree at entry 3
        wait_busy("e3");
        chk("e3_ra",  32'(ra),  32'd3);
        chk("e3_unc", 32'(unc), 32'd1);
        @(negedge clk);
        chk("e3_fix_wa",  32'(wa_o), 32'd3);
        chk("e3_fix_wd",  32'(wd_o), 32'd0);
        chk("e3_fix_pls", 32'(fix),  32'd1);
        chk("e3_unc_off", 32'(unc),  32'd0);
        @(negedge clk);
        chk("e3_cnt", 32'(fix_cnt), 32'd2);

        wait_busy("e4");
        chk("e4_ra", 32'(ra), 32'd4);
        inject(5, 32'h0, 32'h0, 32'hFF);
        inject(6, 32'h55, 32'h0, 32'h0);
        inject(7, 32'h0, 32'h3, 32'h0);

        // core write to the pending fix address cancels the fix
        wait_busy("e5");
        chk("e5_ra", 32'(ra), 32'd5);
        @(posedge clk);
        #1;
        we_i = 1'b1; wa_i = 3'd5; d_i = 32'hAA;
        @(negedge clk);
        chk("e5_we",   32'(we_o), 32'd1);
        chk("e5_wa",   32'(wa_o), 32'd5);
        chk("e5_wd",   32'(wd_o), 32'hAA);
        chk("e5_nofx", 32'(fix),  32'd0);
        chk("e5_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        we_i = 1'b0;
        @(negedge clk);
        chk("e5_cnt",  32'(fix_cnt), 32'd2);
        chk("e5_idle", 32'(busy),    32'd0);
        chk("e5_mem0", mem[0][5],    32'hAA);
        chk("e5_mem2", mem[2][5],    32'hAA);

        // core write elsewhere stalls the fix by one cycle
        wait_busy("e6");
        chk("e6_ra", 32'(ra), 32'd6);
        @(posedge clk);
        #1;
        we_i = 1'b1; wa_i = 3'd1; d_i = 32'h12;
        @(negedge clk);
        chk("e6_st_wa",   32'(wa_o), 32'd1);
        chk("e6_st_wd",   32'(wd_o), 32'h12);
        chk("e6_st_nofx", 32'(fix),  32'd0);
        chk("e6_st_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        we_i = 1'b0;
        @(negedge clk);
        chk("e6_fix_we",  32'(we_o), 32'd1);
        chk("e6_fix_wa",  32'(wa_o), 32'd6);
        chk("e6_fix_wd",  32'(wd_o), 32'd0);
        chk("e6_fix_pls", 32'(fix),  32'd1);
        @(negedge clk);
        chk("e6_cnt", 32'(fix_cnt), 32'd3);
        chk("e6_mem", mem[0][6],    32'd0);

        // core write during READ forces a retry; fix of last entry wraps
        wait_busy("e7");
        chk("e7_ra", 32'(ra), 32'd7);
        we_i = 1'b1; wa_i = 3'd0; d_i = 32'h0;
        @(negedge clk);
        chk("e7_rt_busy", 32'(busy), 32'd1);
        chk("e7_rt_ra",   32'(ra),   32'd7);
        chk("e7_rt_nofx", 32'(fix),  32'd0);
        we_i = 1'b0;
        @(negedge clk);
        chk("e7_fix_pls", 32'(fix),  32'd1);
        chk("e7_fix_wa",  32'(wa_o), 32'd7);
        chk("e7_pass",    32'(pass), 32'd1);
        @(negedge clk);
        chk("e7_cnt", 32'(fix_cnt), 32'd4);

        // reset during FIX aborts the write and restarts at entry 0
        inject(1, 32'h0, 32'h9, 32'h0);
        wait_busy("r0");
        chk("r0_ra", 32'(ra), 32'd0);
        wait_busy("r1");
        chk("r1_ra", 32'(ra), 32'd1);
        @(negedge clk);
        chk("r1_fix_pls", 32'(fix), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ab_we",   32'(we_o),    32'd0);
        chk("ab_fix",  32'(fix),     32'd0);
        chk("ab_busy", 32'(busy),    32'd0);
        chk("ab_cnt",  32'(fix_cnt), 32'd0);
        chk("ab_ra",   32'(ra),      32'd0);
        @(negedge clk);
        chk("ab_mem", mem[1][1], 32'h9);
        rst_n = 1'b1;
        wait_busy("rs0");
        chk("rs0_ra", 32'(ra), 32'd0);
        wait_busy("rs1");
        chk("rs1_ra", 32'(ra), 32'd1);
        @(negedge clk);
        chk("rs1_fix_wa", 32'(wa_o), 32'd1);
        chk("rs1_fix",    32'(fix),  32'd1);
        @(negedge clk);
        chk("rs1_cnt", 32'(fix_cnt), 32'd1);

        // saturation of the fix counter
        inject(2, 32'hF, 32'h0, 32'h0);
        inject(3, 32'hF, 32'h0, 32'h0);
        force dut.fix_cnt_q = 16'hFFFE;
        #1;
        release dut.fix_cnt_q;
        wait_busy("s2");
        @(negedge clk);
        chk("s2_fix", 32'(fix), 32'd1);
        @(negedge clk);
        chk("s2_cnt", 32'(fix_cnt), 32'hFFFF);
        wait_busy("s3");
        @(negedge clk);
        chk("s3_fix", 32'(fix), 32'd1);
        @(negedge clk);
        chk("s3_cnt", 32'(fix_cnt), 32'hFFFF);

        // disable parks the scrubber and keeps the pointer
        en = 1'b0;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        chk("dis_busy", 32'(busy_seen), 32'd0);
        en = 1'b1;
        wait_busy("dis_resume");
        chk("dis_ra", 32'(ra), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
